syscall_responder: RTL
======================

Name: syscall_responder

Overview:
- Service end of the pipeline's syscall request path. The decode stage raises a syscall with a function code and a first parameter; this block executes it.
- Supported services: print signed decimal integer, print character, exit.
- Output is a byte stream (valid/ready) to the console model. Busy and halted flags go back to the hazard unit so it can stall fetch/decode.

Parameters:
- FUNCT_PRINT_INT, 1, syscall code for signed decimal print of param1.
- FUNCT_EXIT, 10, syscall code for halt.
- FUNCT_PRINT_CHAR, 11, syscall code for printing param1[7:0].

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- syscall_valid  input  1  request strobe, sampled only in IDLE
- syscall_funct  input  32  service code
- syscall_param1  input  32  argument
- busy  output  1  registered; high while a request is in progress
- halted  output  1  sticky after exit
- char_data  output  8  ASCII byte
- char_valid  output  1  byte available
- char_ready  input  1  consumer accepts byte when valid&&ready
- bad_funct  output  1  one-cycle pulse on an unsupported code

Behaviour:
- Reset values: busy=0, halted=0, char_valid=0, char_data=8'h00, bad_funct=0, state=IDLE. A reset mid-operation aborts immediately: a pending byte is dropped and digit state is cleared.
- Accept: in IDLE with syscall_valid=1 and halted=0, latch funct/param. busy=1 from the next cycle. While busy or halted, syscall_valid is ignored; the hazard unit must hold the syscall in decode.
- States: IDLE, CONVERT, SIGN, EMIT, CHAR, HALT.
- PRINT_CHAR: IDLE->CHAR. char_valid=1 with data=param[7:0] the cycle after accept. Held stable until the handshake, then ->IDLE with busy=0 the following cycle.
- EXIT: IDLE->HALT. halted=1 and busy=1 from the next cycle and stay so until reset. No bytes are emitted.
- Unknown funct: bad_funct pulses 1 cycle after accept. No state change (stay IDLE, busy stays 0).
- PRINT_INT sign and magnitude:
  - If param1[31]=1, magnitude = two's complement negation as unsigned 32-bit. 0x80000000 yields 2147483648, with no overflow.
- PRINT_INT conversion:
  - CONVERT runs a serial double-dabble into 10 BCD digits, taking exactly 32 cycles with one bit per cycle.
  - Add-3 is applied to any digit >=5 before each shift.
- PRINT_INT output:
  - After CONVERT: go to SIGN if negative (emit '-' = 8'h2D), else straight to EMIT.
  - EMIT outputs digits most-significant first as 8'h30+digit, suppressing leading zeros.
  - Value 0 emits the single byte '0'.
  - Leaves EMIT after the units digit handshakes.
- Byte handshake:
  - char_data/char_valid are registered and must not change while char_valid=1 and char_ready=0.
  - Back-to-back bytes are allowed: next byte valid in the cycle after a handshake, for a maximum of 1 byte/cycle.
  - char_ready is ignored when char_valid=0.
- Latency, PRINT_INT positive, ready tied high: accept at cycle 0, CONVERT cycles 1-32, first byte valid at cycle 33.
- busy falls the cycle after the final handshake.

Optional Feature:
- Macro: SYSCALL_HEX_EN.
- Defined: adds funct 34 (print hex). Emits "0x" followed by exactly 8 lowercase hex digits of param1, with no leading-zero suppression. Skips CONVERT and goes IDLE->EMIT (hex mode).
- Undefined: funct 34 is treated as unknown and pulses bad_funct.

Decomposition:
- Package syscall_pkg: funct code constants (1, 10, 11, 34), ASCII constants ('0', '-', 'x', 'a'), state enumeration, BCD digit width (4) and digit count (10).
- Sub-module bin2bcd_serial: start/done handshake; 32-bit unsigned in, 40-bit BCD out; fixed 32-cycle latency. Instantiated once.
- The FSM, sign handling and emission stay in the top block.

Test Plan:
- PRINT_INT param=1234, ready=1: bytes 31,32,33,34 (hex); first byte at cycle 33; busy low at cycle 38.
- PRINT_INT param=0xFFFFFFF9 (-7): bytes 2D,37. Then param=0x80000000: "-2147483648" (11 bytes). Then param=0: single byte 30.
- PRINT_CHAR param=0x41 with char_ready low for 5 cycles: char_data=41 held steady, valid stays high, a single handshake, no duplicate byte.
- EXIT, then PRINT_CHAR request: halted=1, busy=1, no bytes emitted, second request ignored. A reset pulse clears halted.
- funct=99: bad_funct 1-cycle pulse, busy stays 0. Reset asserted mid-CONVERT of 1234: outputs return to reset values next cycle; a subsequent PRINT_CHAR 0x5A works normally.
- SYSCALL_HEX_EN defined: funct 34 param=0x00AB12CD emits "0x00ab12cd" (10 bytes). Undefined: bad_funct pulses.

Source files
------------

// File: rtl/syscall_pkg.sv
// -----------------------------------------------------------------------------
// syscall_pkg
// Shared definitions for the syscall responder:
//   - syscall function codes
//   - ASCII constants used when building output bytes
//   - FSM state enumeration
//   - BCD geometry (digit width and digit count)
//   - small character helpers
// No ports (package).
// -----------------------------------------------------------------------------
package syscall_pkg;

    localparam logic [31:0] FUNCT_PRINT_INT  = 32'd1;
    localparam logic [31:0] FUNCT_EXIT       = 32'd10;
    localparam logic [31:0] FUNCT_PRINT_CHAR = 32'd11;
    localparam logic [31:0] FUNCT_PRINT_HEX  = 32'd34;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_X     = 8'h78;
    localparam logic [7:0] ASCII_A     = 8'h61;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_DIGITS  = 10;
    localparam int BCD_W       = BCD_DIGIT_W * BCD_DIGITS;
    localparam int BIN_W       = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONVERT = 3'd1,
        ST_SIGN    = 3'd2,
        ST_EMIT    = 3'd3,
        ST_CHAR    = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    // Lowercase ASCII for one hex nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        logic [7:0] r;
        if (n < 4'd10) begin
            r = ASCII_ZERO + {4'd0, n};
        end else begin
            r = ASCII_A + {4'd0, n} - 8'd10;
        end
        return r;
    endfunction

    // ASCII for one decimal digit.
    function automatic logic [7:0] dec_ascii(input logic [3:0] n);
        return ASCII_ZERO + {4'd0, n};
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// -----------------------------------------------------------------------------
// bin2bcd_serial
// Serial double-dabble converter: 32-bit unsigned binary to 10 BCD digits,
// one bit per cycle, fixed 32-cycle latency.
// The first shift is performed on the start edge, so with start in cycle 0
// the result is valid and done is high in cycle 32.
// Ports:
//   clock   in   rising-edge clock
//   reset   in   synchronous active-high reset, aborts a conversion
//   start   in   load bin_in and begin converting (one-cycle strobe)
//   bin_in  in   32-bit unsigned value
//   bcd_out out  40-bit BCD result (digit 9 in [39:36]); held until next start
//   done    out  high for one cycle when bcd_out is final
// -----------------------------------------------------------------------------
module bin2bcd_serial
    import syscall_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BIN_W-1:0]     bin_in,
    output logic [BCD_W-1:0]     bcd_out,
    output logic                 done
);

    // {bcd digits, remaining binary bits}
    logic [BCD_W+BIN_W-1:0] sr_r;
    logic [5:0]             cnt_r;
    logic                   run_r;

    // One double-dabble iteration: add 3 to every digit >= 5, then shift left.
    function automatic logic [BCD_W+BIN_W-1:0] dd_step(input logic [BCD_W+BIN_W-1:0] s);
        logic [BCD_W+BIN_W-1:0] t;
        t = s;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (t[BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W] >= 4'd5) begin
                t[BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W] =
                    t[BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W] + 4'd3;
            end
        end
        return {t[BCD_W+BIN_W-2:0], 1'b0};
    endfunction

    // Shift register, iteration counter and run flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            sr_r  <= '0;
            cnt_r <= 6'd0;
            run_r <= 1'b0;
        end else if (start) begin
            sr_r  <= dd_step({{BCD_W{1'b0}}, bin_in});
            cnt_r <= 6'd1;
            run_r <= 1'b1;
        end else if (run_r) begin
            if (cnt_r == 6'd32) begin
                run_r <= 1'b0;
            end else begin
                sr_r  <= dd_step(sr_r);
                cnt_r <= cnt_r + 6'd1;
            end
        end
    end

    assign bcd_out = sr_r[BCD_W+BIN_W-1:BIN_W];
    assign done    = run_r && (cnt_r == 6'd32);

endmodule

// File: rtl/syscall_responder.sv
// -----------------------------------------------------------------------------
// syscall_responder
// Executes syscalls raised by decode: print signed decimal integer, print
// character, exit. Bytes leave on a registered valid/ready stream.
// Optional build macro SYSCALL_HEX_EN adds funct 34 (print "0x" + 8 lowercase
// hex digits); without it funct 34 is reported as unsupported.
// Ports:
//   clock          in   rising-edge clock
//   reset          in   synchronous active-high reset
//   syscall_valid  in   request strobe, sampled only when idle
//   syscall_funct  in   32-bit service code
//   syscall_param1 in   32-bit argument
//   busy           out  registered, high while a request is in progress
//   halted         out  sticky after exit until reset
//   char_data      out  ASCII byte
//   char_valid     out  byte available
//   char_ready     in   consumer accepts when valid && ready
//   bad_funct      out  one-cycle pulse for an unsupported code
// -----------------------------------------------------------------------------
module syscall_responder
    import syscall_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        syscall_valid,
    input  logic [31:0] syscall_funct,
    input  logic [31:0] syscall_param1,
    output logic        busy,
    output logic        halted,
    output logic [7:0]  char_data,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        bad_funct
);

    state_t             state_r, state_n;
    logic               busy_r, busy_n;
    logic               halted_r, halted_n;
    logic               char_valid_r, char_valid_n;
    logic [7:0]         char_data_r, char_data_n;
    logic               bad_funct_r, bad_funct_n;
    logic [3:0]         idx_r, idx_n;          // digit position being emitted
    logic [BCD_W-1:0]   digits_r, digits_n;    // BCD digits, or raw value in hex mode
    logic               neg_r, neg_n;
    logic               hex_r, hex_n;

    logic               conv_start_s;
    logic               conv_done_s;
    logic [BCD_W-1:0]   conv_bcd_s;
    logic [BIN_W-1:0]   mag_s;
    logic               hs_s;

    // Byte for position i. In hex mode positions 9 and 8 carry the "0x" prefix
    // and 7..0 the nibbles of the raw value.
    function automatic logic [7:0] emit_byte(input logic [BCD_W-1:0] d,
                                             input logic [3:0] i,
                                             input logic hex);
        logic [3:0] nib;
        logic [7:0] r;
        nib = d[{i, 2'b00} +: 4];
        if (hex) begin
            if (i == 4'd9) begin
                r = ASCII_ZERO;
            end else if (i == 4'd8) begin
                r = ASCII_X;
            end else begin
                r = hex_ascii(nib);
            end
        end else begin
            r = dec_ascii(nib);
        end
        return r;
    endfunction

    // Highest non-zero digit position; 0 when the value is zero so that a
    // single '0' is emitted.
    function automatic logic [3:0] lead_idx(input logic [BCD_W-1:0] d);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            if (d[BCD_DIGIT_W*k +: BCD_DIGIT_W] != 4'd0) begin
                r = 4'(k);
            end
        end
        return r;
    endfunction

    // Magnitude of the signed argument; 0x80000000 maps to 2147483648.
    assign mag_s = syscall_param1[31] ? (32'd0 - syscall_param1) : syscall_param1;
    assign hs_s  = char_valid_r && char_ready;

    bin2bcd_serial u_bin2bcd (
        .clock   (clock),
        .reset   (reset),
        .start   (conv_start_s),
        .bin_in  (mag_s),
        .bcd_out (conv_bcd_s),
        .done    (conv_done_s)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_n      = state_r;
        halted_n     = halted_r;
        char_valid_n = char_valid_r;
        char_data_n  = char_data_r;
        bad_funct_n  = 1'b0;
        idx_n        = idx_r;
        digits_n     = digits_r;
        neg_n        = neg_r;
        hex_n        = hex_r;
        conv_start_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // busy_r lingers one cycle after a request ends; requests are
                // only taken once it has dropped.
                if (syscall_valid && !busy_r && !halted_r) begin
                    case (syscall_funct)
                        FUNCT_PRINT_INT: begin
                            conv_start_s = 1'b1;
                            neg_n        = syscall_param1[31];
                            hex_n        = 1'b0;
                            state_n      = ST_CONVERT;
                        end
                        FUNCT_EXIT: begin
                            halted_n = 1'b1;
                            state_n  = ST_HALT;
                        end
                        FUNCT_PRINT_CHAR: begin
                            char_valid_n = 1'b1;
                            char_data_n  = syscall_param1[7:0];
                            state_n      = ST_CHAR;
                        end
`ifdef SYSCALL_HEX_EN
                        FUNCT_PRINT_HEX: begin
                            hex_n        = 1'b1;
                            digits_n     = {8'h00, syscall_param1};
                            idx_n        = 4'd9;
                            char_valid_n = 1'b1;
                            char_data_n  = ASCII_ZERO;
                            state_n      = ST_EMIT;
                        end
`endif
                        default: begin
                            bad_funct_n = 1'b1;
                        end
                    endcase
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_CONVERT: begin
                if (conv_done_s) begin
                    digits_n     = conv_bcd_s;
                    idx_n        = lead_idx(conv_bcd_s);
                    char_valid_n = 1'b1;
                    if (neg_r) begin
                        char_data_n = ASCII_MINUS;
                        state_n     = ST_SIGN;
                    end else begin
                        char_data_n = emit_byte(conv_bcd_s, lead_idx(conv_bcd_s), 1'b0);
                        state_n     = ST_EMIT;
                    end
                end else begin
                    state_n = ST_CONVERT;
                end
            end
            ST_SIGN: begin
                if (hs_s) begin
                    char_data_n = emit_byte(digits_r, idx_r, hex_r);
                    state_n     = ST_EMIT;
                end else begin
                    state_n = ST_SIGN;
                end
            end
            ST_EMIT: begin
                if (hs_s) begin
                    if (idx_r == 4'd0) begin
                        char_valid_n = 1'b0;
                        state_n      = ST_IDLE;
                    end else begin
                        idx_n       = idx_r - 4'd1;
                        char_data_n = emit_byte(digits_r, idx_r - 4'd1, hex_r);
                    end
                end else begin
                    state_n = ST_EMIT;
                end
            end
            ST_CHAR: begin
                if (hs_s) begin
                    char_valid_n = 1'b0;
                    state_n      = ST_IDLE;
                end else begin
                    state_n = ST_CHAR;
                end
            end
            ST_HALT: begin
                state_n = ST_HALT;
            end
            default: begin
                char_valid_n = 1'b0;
                state_n      = ST_IDLE;
            end
        endcase

        // Rises with the accept edge, falls one cycle after returning to idle.
        busy_n = (state_n != ST_IDLE) || (state_r != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            halted_r     <= 1'b0;
            char_valid_r <= 1'b0;
            char_data_r  <= 8'h00;
            bad_funct_r  <= 1'b0;
            idx_r        <= 4'd0;
            digits_r     <= '0;
            neg_r        <= 1'b0;
            hex_r        <= 1'b0;
        end else begin
            state_r      <= state_n;
            busy_r       <= busy_n;
            halted_r     <= halted_n;
            char_valid_r <= char_valid_n;
            char_data_r  <= char_data_n;
            bad_funct_r  <= bad_funct_n;
            idx_r        <= idx_n;
            digits_r     <= digits_n;
            neg_r        <= neg_n;
            hex_r        <= hex_n;
        end
    end

    assign busy       = busy_r;
    assign halted     = halted_r;
    assign char_valid = char_valid_r;
    assign char_data  = char_data_r;
    assign bad_funct  = bad_funct_r;

endmodule
